if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset rst, synchronous, active-high.
REQ-003 stall_i  in  1  decode stage not accepting; holds the current head instruction.
REQ-004 flush_i  in  1  redirect request from a later stage.
REQ-005 redirect_pc_i  in  32  new fetch address, sampled when flush_i=1.
REQ-006 mem_req_o  out  1  instruction-memory word request.
REQ-007 mem_addr_o  out  32  byte address of requested word.
REQ-008 mem_ack_i  in  1  word returned this cycle; meaningful only while mem_req_o=1.
REQ-009 mem_rdata_i  in  32  returned word.
REQ-010 pc_o  out  32  address of instruction presented to decode.
REQ-011 inst_o  out  64  instruction presented to decode.
REQ-012 inst_valid_o  out  1  pc_o/inst_o hold a valid instruction.

Function
REQ-013 Each 64-bit instruction SHALL be assembled from two words: word at PC -> inst[63:32], word at PC+4 -> inst[31:0].
REQ-014 The fetch PC SHALL advance by 8 per completed instruction, wrapping modulo 2^32.
REQ-015 The FSM SHALL have states IDLE, REQ_HI, REQ_LO.
REQ-016 REQ_HI: mem_req_o=1, mem_addr_o=fetch PC; on mem_ack_i capture the high word and go to REQ_LO.
REQ-017 REQ_LO: mem_req_o=1, mem_addr_o=fetch PC+4; on mem_ack_i push {PC, hi, rdata} into the buffer, advance PC, then go to REQ_HI if a slot remains, else IDLE.
REQ-018 The FSM SHALL enter REQ_HI only when the buffer, counting the instruction being assembled, has a free slot; otherwise it SHALL remain in IDLE with mem_req_o=0.
REQ-019 mem_addr_o SHALL stay stable while mem_req_o=1 and no ack has occurred.
REQ-020 The buffer SHALL be a 2-entry FIFO of {pc, inst}; pc_o/inst_o SHALL be driven combinationally from its head.
REQ-021 inst_valid_o SHALL equal buffer-not-empty; when empty, pc_o=0 and inst_o=0 (NOP).
REQ-022 A pop SHALL occur when inst_valid_o=1 and stall_i=0; simultaneous push and pop SHALL leave the count unchanged.
REQ-023 Latency: ack of the low word in cycle N SHALL make the instruction visible (if buffer was empty) in cycle N+1.
REQ-024 flush_i=1 SHALL, in the same edge, empty the buffer, discard any partial high word, ignore any mem_ack_i in that cycle, load fetch PC with {redirect_pc_i[31:3], 3'b000} and enter REQ_HI.
REQ-025 flush_i SHALL take priority over stall_i, push and pop.
REQ-026 mem_req_o MAY drop without ack only on flush or reset; the memory SHALL treat this as an abandoned request.
REQ-027 stall_i SHALL NOT stop fetching while a buffer slot is free.

Reset
REQ-028 While rst=1: mem_req_o=0, inst_valid_o=0, pc_o=0, inst_o=0, buffer empty, fetch PC=0, state REQ_HI entered on the first edge with rst=0.
REQ-029 rst mid-request SHALL abandon the request; a partially assembled instruction SHALL be discarded.

Structure
REQ-030 `InstAddrBus`, `InstBus`, `ZeroWord`, `RstEnable`, the new `FetchDepth` (2) and the FSM state encodings SHALL be in defines.v.
REQ-031 The FIFO SHALL be a sub-module named inst_fifo (96-bit entries, push/pop/flush, count, full/empty).
REQ-032 The FSM, PC counter and high-word holding register SHALL be in if_fetch.

Verification
REQ-033 Reset release, memory acks every request in the same cycle, stall_i=0 -> addrs 0,4,8,12; inst_valid_o first high in cycle 3 with pc_o=0.
REQ-034 stall_i held high -> buffer fills with PC 0 and 8; mem_req_o=0 thereafter; pc_o stays 0 until stall_i drops, then 8.
REQ-035 Word 0x12345678 at 0x0 and 0x9ABCDEF0 at 0x4 -> inst_o=0x123456789ABCDEF0.
REQ-036 flush_i with redirect_pc_i=0x105 while in REQ_LO with ack asserted -> ack ignored, inst_valid_o=0 next cycle, next mem_addr_o=0x100.
REQ-037 Buffer full, pop and low-word ack in the same cycle -> count stays 2, order preserved.
REQ-038 Fetch PC=0xFFFFFFF8 -> next instruction PC wraps to 0x0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants, FSM state encoding and helpers for the instruction fetch slice.
// Fetches 64-bit instructions as two 32-bit memory words.
package if_fetch_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 64;
  localparam int          FetchDepth  = 2;
  localparam int          EntryW      = InstAddrBus + InstBus;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } fetch_state_e;

  // Instructions are 8-byte aligned, so redirect targets drop their low three bits.
  function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory word bus between the fetch unit (master) and memory (slave).
// The slave may acknowledge in the same cycle as the request.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   mem_req_o;
  logic [InstAddrBus-1:0] mem_addr_o;
  logic                   mem_ack_i;
  logic [31:0]            mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/if_fetch_inst_fifo.sv
// Two-entry FIFO of {pc, inst}; head is presented combinationally.
// Flush empties it; a push into a full FIFO is accepted only alongside a pop.
module inst_fifo
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [EntryW-1:0] i_data,
  output logic [EntryW-1:0] o_data,
  output logic [1:0]        o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [EntryW-1:0] r_mem [0:FetchDepth-1];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? {EntryW{1'b0}} : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst == RstEnable || i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= {EntryW{1'b0}};
      r_mem[1] <= {EntryW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 64-bit instructions from two word reads and queues
// them in a two-entry buffer in front of decode. flush redirects fetch immediately.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [InstAddrBus-1:0] redirect_pc_i,
  if_fetch_if.master             mem,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o
);

  fetch_state_e           r_state;
  fetch_state_e           w_state_nxt;
  logic [InstAddrBus-1:0] r_pc;
  logic [31:0]            r_hi;
  logic                   w_in_rst;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_req;
  logic [InstAddrBus-1:0] w_addr;
  logic [EntryW-1:0]      w_head;
  logic [1:0]             w_count;
  logic                   w_full;
  logic                   w_empty;

  assign w_in_rst     = (rst == RstEnable);
  assign inst_valid_o = !w_empty && !w_in_rst;
  assign pc_o         = inst_valid_o ? w_head[EntryW-1:InstBus] : ZeroWord;
  assign inst_o       = inst_valid_o ? w_head[InstBus-1:0] : {InstBus{1'b0}};
  assign w_pop        = inst_valid_o && !stall_i && !flush_i;
  assign mem.mem_req_o  = w_req && !w_in_rst;
  assign mem.mem_addr_o = w_addr;

  // Next state, bus request and buffer push; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_addr      = ZeroWord;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_full || w_pop) begin
          w_state_nxt = REQ_HI;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ_HI: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (mem.mem_ack_i) begin
          w_state_nxt = REQ_LO;
        end else begin
          w_state_nxt = REQ_HI;
        end
      end
      REQ_LO: begin
        w_req  = 1'b1;
        w_addr = r_pc + 32'd4;
        if (mem.mem_ack_i) begin
          w_push = 1'b1;
          // After this push a slot remains only if the buffer was empty or drains now.
          if (w_count == 2'd0 || w_pop) begin
            w_state_nxt = REQ_HI;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = REQ_LO;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (flush_i) begin
      w_state_nxt = REQ_HI;
      w_push      = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // FSM state, fetch PC and the held high word.
  always_ff @(posedge clk) begin
    if (w_in_rst) begin
      r_state <= IDLE;
      r_pc    <= ZeroWord;
      r_hi    <= 32'h0000_0000;
    end else if (flush_i) begin
      r_state <= REQ_HI;
      r_pc    <= align_pc(redirect_pc_i);
      r_hi    <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == REQ_HI && mem.mem_ack_i) begin
        r_hi <= mem.mem_rdata_i;
      end
      if (w_push) begin
        r_pc <= r_pc + 32'd8;
      end
    end
  end

  inst_fifo u_inst_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush_i),
    .i_data  ({r_pc, r_hi, mem.mem_rdata_i}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed fetch/stall/flush/wrap scenarios; a
// monitor compares every instruction decode consumes against the expected queue.
module tb_if_fetch;
  import if_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] pc_o;
  logic [63:0] inst_o;
  logic        inst_valid;
  logic        ack_en;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];

  if_fetch_if bus ();

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_pc_i (redirect_pc),
    .mem           (bus),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h1234_5678;
    if (a == 32'h0000_0004) return 32'h9ABC_DEF0;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = {mem_word(pc), mem_word(pc + 32'd4)};
    return e;
  endfunction

  assign bus.mem_ack_i   = bus.mem_req_o & ack_en;
  assign bus.mem_rdata_i = mem_word(bus.mem_addr_o);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cond_addr(input string name, input logic want_req, input logic [31:0] addr);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_req_o == want_req && (!want_req || bus.mem_addr_o == addr)) begin
        check(name, 64'(bus.mem_addr_o), want_req ? 64'(addr) : 64'(bus.mem_addr_o));
        return;
      end
    end
    check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pop_one();
    for (int i = 0; i < 40; i++) begin
      if (inst_valid) break;
      @(negedge clk);
    end
    #1 stall = 1'b0;
    @(negedge clk);
    #1 stall = 1'b1;
  endtask

  // Monitor: sample just before the active edge and score every consumed instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && inst_valid && !stall && !flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got pc %h with empty expected queue", pc_o);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", 64'(pc_o), 64'(e.pc));
          check("pop_inst", inst_o, e.inst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b1; flush = 1'b0; redirect_pc = 32'h0; ack_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(bus.mem_req_o), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_pc", 64'(pc_o), 64'd0);
    check("rst_inst", inst_o, 64'd0);
    #1 rst = 1'b0;

    // Fill from reset with decode stalled.
    @(negedge clk); check("addr0", {31'd0, bus.mem_req_o, bus.mem_addr_o}, {31'd0, 1'b1, 32'h0});
    @(negedge clk); check("addr4", 64'(bus.mem_addr_o), 64'h4);
    @(negedge clk);
    check("first_valid", 64'(inst_valid), 64'd1);
    check("first_pc", 64'(pc_o), 64'd0);
    check("first_inst", inst_o, 64'h1234_5678_9ABC_DEF0);
    check("addr8", 64'(bus.mem_addr_o), 64'h8);
    @(negedge clk); check("addr12", 64'(bus.mem_addr_o), 64'hC);
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h8));
    repeat (3) begin
      @(negedge clk);
      check("full_no_req", 64'(bus.mem_req_o), 64'd0);
      check("stall_hold_pc", 64'(pc_o), 64'd0);
    end
    pop_one();
    check("after_pop_pc", 64'(pc_o), 64'h8);
    exp_q.push_back(mk(32'h10));
    wait_cond_addr("refill_idle", 1'b0, 32'h0);

    // Flush from a full buffer, then flush again while a low-word ack is present.
    #1 flush = 1'b1; redirect_pc = 32'h0000_00F0; exp_q.delete();
    @(negedge clk);
    check("flush1_valid", 64'(inst_valid), 64'd0);
    check("flush1_addr", {31'd0, bus.mem_req_o, bus.mem_addr_o}, {31'd0, 1'b1, 32'hF0});
    #1 flush = 1'b0;
    @(negedge clk);
    check("reqlo_addr", 64'(bus.mem_addr_o), 64'hF4);
    #1 flush = 1'b1; redirect_pc = 32'h0000_0105;
    @(negedge clk);
    check("flush2_valid", 64'(inst_valid), 64'd0);
    check("flush2_addr", 64'(bus.mem_addr_o), 64'h100);
    #1 flush = 1'b0;
    exp_q.push_back(mk(32'h100));
    exp_q.push_back(mk(32'h108));

    // Pop coincides with the low-word ack: occupancy holds and order is kept.
    wait_cond_addr("reach_10c", 1'b1, 32'h10C);
    #1 stall = 1'b0;
    @(negedge clk);
    check("pushpop_pc", 64'(pc_o), 64'h108);
    check("pushpop_valid", 64'(inst_valid), 64'd1);
    check("pushpop_addr", 64'(bus.mem_addr_o), 64'h110);
    #1 stall = 1'b1;
    exp_q.push_back(mk(32'h110));
    wait_cond_addr("pushpop_idle", 1'b0, 32'h0);
    pop_one();
    pop_one();

    // Wrap at the top of the address space, with acks held off for a few cycles.
    @(negedge clk);
    #1 flush = 1'b1; redirect_pc = 32'hFFFF_FFFF; ack_en = 1'b0; exp_q.delete();
    @(negedge clk);
    check("wrap_addr", 64'(bus.mem_addr_o), 64'hFFFF_FFF8);
    #1 flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("addr_stable", {31'd0, bus.mem_req_o, bus.mem_addr_o}, {31'd0, 1'b1, 32'hFFFF_FFF8});
    end
    #1 ack_en = 1'b1;
    exp_q.push_back(mk(32'hFFFF_FFF8));
    exp_q.push_back(mk(32'h0));
    wait_cond_addr("wrap_to_0", 1'b1, 32'h0);
    pop_one();
    pop_one();
    repeat (4) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
